// File: rtl/edge_gen_pkg.sv
// Shared types and constants for the edge generator.
package edge_gen_pkg;

    // Output level FSM: each level has a ready state and a dwell state.
    typedef enum logic [1:0] {
        LOW_RDY    = 2'd0,
        LOW_DWELL  = 2'd1,
        HIGH_RDY   = 2'd2,
        HIGH_DWELL = 2'd3
    } state_e;

    // Width of the queued-toggle counter.
    localparam int PEND_W = 4;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that times the minimum dwell at the current level.
module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load takes priority, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The decrement in this cycle reaches zero, so the dwell ends at this edge.
    assign expired = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/edge_generator.sv
// Turns rise/fall/toggle request pulses into a registered level with
// guaranteed minimum high and low dwell, queueing requests made during a dwell.
// Handshake note: requests are fire-and-forget pulses with no ready; a request
// that finds the queue full is dropped and flagged on err_ovf.
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4,
    parameter int CNT_W    = 8,
    parameter int PEND_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev_rise,
    input  logic              ev_fall,
    input  logic              ev_toggle,
    input  logic              clr_err,
    output logic              sig_out,
    output logic              edge_stb,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              err_ovf,
    output logic              err_conf
);

    state_e            state_q, state_d;
    logic              req_lvl_q, req_lvl_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              sig_out_q, sig_out_d;
    logic              edge_stb_q, edge_stb_d;
    logic              busy_q, busy_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_conf_q, err_conf_d;

    logic              conflict;
    logic              enq_req;
    logic              enq_ok;
    logic              drop;
    logic              deq;
    logic              dwell_load;
    logic [CNT_W-1:0]  dwell_val;
    logic              dwell_expired;

    dwell_timer #(
        .CNT_W(CNT_W)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .load    (dwell_load),
        .load_val(dwell_val),
        .expired (dwell_expired)
    );

    // Request decode: turn level requests into toggles relative to req_lvl.
    always_comb begin
        conflict = ev_rise & ev_fall;
        enq_req  = 1'b0;
        if (conflict) begin
            enq_req = 1'b0;
        end else if (ev_rise) begin
            enq_req = ~req_lvl_q;
        end else if (ev_fall) begin
            enq_req = req_lvl_q;
        end else begin
            enq_req = ev_toggle;
        end
        drop      = enq_req & (pending_q == PEND_W'(PEND_MAX));
        enq_ok    = enq_req & ~drop;
        req_lvl_d = enq_ok ? ~req_lvl_q : req_lvl_q;
    end

    // FSM next state: dequeue one toggle from a ready state, then dwell.
    always_comb begin
        state_d    = state_q;
        sig_out_d  = sig_out_q;
        deq        = 1'b0;
        dwell_load = 1'b0;
        dwell_val  = '0;
        case (state_q)
            LOW_RDY: begin
                if (pending_q != '0) begin
                    deq        = 1'b1;
                    sig_out_d  = 1'b1;
                    dwell_load = 1'b1;
                    dwell_val  = CNT_W'(MIN_HIGH - 1);
                    state_d    = (MIN_HIGH == 1) ? HIGH_RDY : HIGH_DWELL;
                end
            end
            HIGH_DWELL: begin
                if (dwell_expired) begin
                    state_d = HIGH_RDY;
                end
            end
            HIGH_RDY: begin
                if (pending_q != '0) begin
                    deq        = 1'b1;
                    sig_out_d  = 1'b0;
                    dwell_load = 1'b1;
                    dwell_val  = CNT_W'(MIN_LOW - 1);
                    state_d    = (MIN_LOW == 1) ? LOW_RDY : LOW_DWELL;
                end
            end
            LOW_DWELL: begin
                if (dwell_expired) begin
                    state_d = LOW_RDY;
                end
            end
            default: begin
                state_d = LOW_RDY;
            end
        endcase
    end

    // Queue count, strobe, busy and sticky error next values.
    always_comb begin
        pending_d = pending_q;
        case ({enq_ok, deq})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
        edge_stb_d = deq;
        busy_d     = (pending_d != '0) || (state_d == LOW_DWELL) || (state_d == HIGH_DWELL);
        err_ovf_d  = drop | (err_ovf_q & ~clr_err);
        err_conf_d = conflict | (err_conf_q & ~clr_err);
    end

    // State and output registers; reset discards any queued or dwelling work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOW_RDY;
            req_lvl_q  <= 1'b0;
            pending_q  <= '0;
            sig_out_q  <= 1'b0;
            edge_stb_q <= 1'b0;
            busy_q     <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_conf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_lvl_q  <= req_lvl_d;
            pending_q  <= pending_d;
            sig_out_q  <= sig_out_d;
            edge_stb_q <= edge_stb_d;
            busy_q     <= busy_d;
            err_ovf_q  <= err_ovf_d;
            err_conf_q <= err_conf_d;
        end
    end

    assign sig_out  = sig_out_q;
    assign edge_stb = edge_stb_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign err_ovf  = err_ovf_q;
    assign err_conf = err_conf_q;

endmodule

// File: tb/tb_edge_generator.sv
// Directed bench for edge_generator: default dwell instance plus a 1-cycle dwell instance.
module tb_edge_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       ev_rise, ev_fall, ev_toggle, clr_err;

    logic       sig_out, edge_stb, busy, err_ovf, err_conf;
    logic [3:0] pending;
    logic       d1_sig_out, d1_edge_stb, d1_busy, d1_err_ovf, d1_err_conf;
    logic [3:0] d1_pending;

    int n_checks = 0;
    int n_fail   = 0;

    edge_generator #(
        .MIN_HIGH(4), .MIN_LOW(4), .CNT_W(8), .PEND_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .ev_rise(ev_rise), .ev_fall(ev_fall), .ev_toggle(ev_toggle), .clr_err(clr_err),
        .sig_out(sig_out), .edge_stb(edge_stb), .busy(busy), .pending(pending),
        .err_ovf(err_ovf), .err_conf(err_conf)
    );

    edge_generator #(
        .MIN_HIGH(1), .MIN_LOW(1), .CNT_W(8), .PEND_MAX(3)
    ) dut1 (
        .clk(clk), .rst(rst),
        .ev_rise(ev_rise), .ev_fall(ev_fall), .ev_toggle(ev_toggle), .clr_err(clr_err),
        .sig_out(d1_sig_out), .edge_stb(d1_edge_stb), .busy(d1_busy), .pending(d1_pending),
        .err_ovf(d1_err_ovf), .err_conf(d1_err_conf)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ev_rise   = 1'b0;
        ev_fall   = 1'b0;
        ev_toggle = 1'b0;
        clr_err   = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b0;
        ev_rise = 1'b0; ev_fall = 1'b0; ev_toggle = 1'b0; clr_err = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_sig", sig_out, 0);
        check("rst_stb", edge_stb, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", err_ovf, 0);
        check("rst_conf", err_conf, 0);
        rst = 1'b1;
        idle(2);

        // Single rise: queued at N, output at N+1, idle after N+4
        ev_rise = 1'b1; tick(); ev_rise = 1'b0;
        check("rise_pend_n", pending, 1);
        check("rise_sig_n", sig_out, 0);
        check("rise_busy_n", busy, 1);
        tick();
        check("rise_sig_n1", sig_out, 1);
        check("rise_stb_n1", edge_stb, 1);
        check("rise_pend_n1", pending, 0);
        check("rise_busy_n1", busy, 1);
        tick();
        check("rise_stb_n2", edge_stb, 0);
        check("rise_busy_n2", busy, 1);
        tick();
        check("rise_busy_n3", busy, 1);
        tick();
        check("rise_busy_n4", busy, 0);
        check("rise_sig_n4", sig_out, 1);

        // Redundant rises while already high
        ev_rise = 1'b1; tick(); ev_rise = 1'b0;
        check("redund_pend1", pending, 0);
        tick();
        ev_rise = 1'b1; tick(); ev_rise = 1'b0;
        check("redund_pend2", pending, 0);
        check("redund_stb", edge_stb, 0);
        tick();
        check("redund_sig", sig_out, 1);
        check("redund_stb2", edge_stb, 0);
        check("redund_conf", err_conf, 0);
        check("redund_ovf", err_ovf, 0);
        check("redund_busy", busy, 0);

        // Return low and let the low dwell finish
        ev_fall = 1'b1; tick(); ev_fall = 1'b0;
        check("fall_pend", pending, 1);
        tick();
        check("fall_sig", sig_out, 0);
        check("fall_stb", edge_stb, 1);
        idle(5);
        check("fall_idle_busy", busy, 0);

        // Fall requested during the high dwell lands exactly MIN_HIGH after the rise
        ev_rise = 1'b1; tick(); ev_rise = 1'b0;
        tick();
        check("fdw_sig_n1", sig_out, 1);
        check("fdw_stb_n1", edge_stb, 1);
        ev_fall = 1'b1; tick(); ev_fall = 1'b0;
        check("fdw_pend_n2", pending, 1);
        tick();
        check("fdw_pend_n3", pending, 1);
        check("fdw_sig_n3", sig_out, 1);
        tick();
        check("fdw_pend_n4", pending, 1);
        check("fdw_sig_n4", sig_out, 1);
        check("fdw_stb_n4", edge_stb, 0);
        tick();
        check("fdw_sig_n5", sig_out, 0);
        check("fdw_stb_n5", edge_stb, 1);
        check("fdw_pend_n5", pending, 0);
        idle(5);

        // Overflow: five toggles, the fifth dropped, four edges 4 cycles apart
        ev_toggle = 1'b1; tick();
        check("ovf_pend_e0", pending, 1);
        tick();
        check("ovf_sig_e1", sig_out, 1);
        check("ovf_stb_e1", edge_stb, 1);
        check("ovf_pend_e1", pending, 1);
        tick();
        check("ovf_pend_e2", pending, 2);
        tick();
        check("ovf_pend_e3", pending, 3);
        check("ovf_err_e3", err_ovf, 0);
        tick(); ev_toggle = 1'b0;
        check("ovf_pend_e4", pending, 3);
        check("ovf_err_e4", err_ovf, 1);
        for (int k = 5; k <= 16; k++) begin
            tick();
            check($sformatf("ovf_stb_e%0d", k), edge_stb, (k == 5 || k == 9 || k == 13) ? 1 : 0);
            check($sformatf("ovf_sig_e%0d", k), sig_out, (k >= 9 && k <= 12) ? 1 : 0);
        end
        check("ovf_end_pend", pending, 0);
        check("ovf_end_busy", busy, 0);

        // Conflict: rise+fall+toggle together does nothing but flag err_conf
        ev_rise = 1'b1; ev_fall = 1'b1; ev_toggle = 1'b1; tick();
        ev_rise = 1'b0; ev_fall = 1'b0; ev_toggle = 1'b0;
        check("conf_pend", pending, 0);
        check("conf_err", err_conf, 1);
        check("conf_sig", sig_out, 0);
        check("conf_ovf_sticky", err_ovf, 1);
        tick();
        check("conf_sig2", sig_out, 0);
        check("conf_stb2", edge_stb, 0);
        check("conf_busy2", busy, 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("clr_conf", err_conf, 0);
        check("clr_ovf", err_ovf, 0);
        clr_err = 1'b1; ev_rise = 1'b1; ev_fall = 1'b1; tick();
        clr_err = 1'b0; ev_rise = 1'b0; ev_fall = 1'b0;
        check("setwins_conf", err_conf, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("clr_conf2", err_conf, 0);

        // Reset mid-dwell with two toggles queued
        ev_toggle = 1'b1; tick(); tick(); tick(); ev_toggle = 1'b0;
        check("rmd_pend", pending, 2);
        check("rmd_sig", sig_out, 1);
        check("rmd_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rmd_async_sig", sig_out, 0);
        check("rmd_async_pend", pending, 0);
        check("rmd_async_busy", busy, 0);
        tick();
        rst = 1'b1;
        idle(4);
        check("rmd_after_sig", sig_out, 0);
        check("rmd_after_stb", edge_stb, 0);
        check("rmd_after_pend", pending, 0);
        ev_rise = 1'b1; tick(); ev_rise = 1'b0;
        tick();
        check("rmd_newrise_sig", sig_out, 1);
        check("rmd_newrise_stb", edge_stb, 1);

        // One-cycle dwell instance: back-to-back toggles alternate every cycle
        rst = 1'b0; tick(); rst = 1'b1; tick();
        ev_toggle = 1'b1; tick();
        check("b2b_pend_e0", d1_pending, 1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) ev_toggle = 1'b0;
            tick();
            check($sformatf("b2b_sig_e%0d", k), d1_sig_out, (k % 2 == 1) ? 1 : 0);
            check($sformatf("b2b_stb_e%0d", k), d1_edge_stb, 1);
        end
        check("b2b_end_pend", d1_pending, 0);
        check("b2b_end_busy", d1_busy, 0);
        tick();
        check("b2b_quiet_stb", d1_edge_stb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
